branch_comp_iter: RTL and testbench

BRANCH_COMP_ITER -- requirements
Module: branch_comp_iter

---
 rtl/br_pkg.sv | 43 ++++
 rtl/branch_chunk_cmp.sv | 26 ++
 rtl/branch_comp_iter.sv | 153 +++++++++++++++
 tb/tb_branch_comp_iter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/br_pkg.sv
// Shared types for the iterative branch comparator:
// branch condition encoding, FSM states and the condition resolver.
package br_pkg;

  localparam int BR_OP_W = 3;

  typedef enum logic [BR_OP_W-1:0] {
    EQ  = 3'd0,
    NE  = 3'd1,
    LT  = 3'd4,
    GE  = 3'd5,
    LTU = 3'd6,
    GEU = 3'd7
  } br_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic br_signed(br_op_t op);
    return (op == LT) || (op == GE);
  endfunction

  function automatic logic br_resolve(
    br_op_t op,
    logic   lt,
    logic   ne
  );
    logic r;
    r = 1'b0;
    unique case (1'b1)
      (op == EQ):                r = !ne;
      (op == NE):                r = ne;
      (op == LT) || (op == LTU): r = lt;
      (op == GE) || (op == GEU): r = !lt;
      default:                   r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/branch_chunk_cmp.sv
// Single-chunk magnitude compare; sign_fix flips the chunk MSB
// so a signed top chunk can be ordered with an unsigned compare.
module branch_chunk_cmp #(
  parameter int W = 8
) (
  input  logic [W-1:0] chunk_a,
  input  logic [W-1:0] chunk_b,
  input  logic         sign_fix,
  output logic         eq,
  output logic         lt
);

  logic [W-1:0] ua;
  logic [W-1:0] ub;

  always_comb begin
    ua = chunk_a;
    ub = chunk_b;
    ua[W-1] = chunk_a[W-1] ^ sign_fix;
    ub[W-1] = chunk_b[W-1] ^ sign_fix;
  end

  assign eq = (ua == ub);
  assign lt = (ua < ub);

endmodule

// File: rtl/branch_comp_iter.sv
// Iterative branch comparator: walks the operands one chunk per
// cycle from the MSB end and resolves the branch condition.
module branch_comp_iter
  import br_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int CHUNK      = 8,
  parameter int EARLY_EXIT = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  br_op_t          br_op,
  input  logic            pred_taken,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            taken,
  output logic            mispredict
);

  localparam int NCHUNK = XLEN / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(NCHUNK - 1);

  generate
    if (XLEN % CHUNK != 0) begin : g_bad_chunk
      $error("XLEN must be a multiple of CHUNK");
    end
  endgenerate

  state_t          state, state_n;
  logic [IDXW-1:0] idx, idx_n;
  logic [XLEN-1:0] a_q, a_n;
  logic [XLEN-1:0] b_q, b_n;
  br_op_t          op_q, op_n;
  logic            pred_q, pred_n;
  logic            lt_q, lt_n;
  logic            ne_q, ne_n;
  logic            tk_q, tk_n;
  logic            mp_q, mp_n;

  logic sign_fix;
  logic c_eq;
  logic c_lt;
  logic lt_c;
  logic ne_c;
  logic fin;
  logic res;

  // Operands shift left each cycle, so the live chunk is always on top.
  assign sign_fix = (idx == '0) && br_signed(op_q);

  branch_chunk_cmp #(
    .W(CHUNK)
  ) u_cmp (
    .chunk_a  (a_q[XLEN-1 -: CHUNK]),
    .chunk_b  (b_q[XLEN-1 -: CHUNK]),
    .sign_fix (sign_fix),
    .eq       (c_eq),
    .lt       (c_lt)
  );

  always_comb begin
    lt_c = ne_q ? lt_q : c_lt;
    ne_c = ne_q | !c_eq;
    fin  = (idx == LAST) || ((EARLY_EXIT != 0) && !c_eq);
    res  = br_resolve(op_q, lt_c, ne_c);
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    a_n     = a_q;
    b_n     = b_q;
    op_n    = op_q;
    pred_n  = pred_q;
    lt_n    = lt_q;
    ne_n    = ne_q;
    tk_n    = tk_q;
    mp_n    = mp_q;
    if (flush) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_n     = a;
            b_n     = b;
            op_n    = br_op;
            pred_n  = pred_taken;
            idx_n   = '0;
            lt_n    = 1'b0;
            ne_n    = 1'b0;
            state_n = BUSY;
          end
        end
        BUSY: begin
          lt_n = lt_c;
          ne_n = ne_c;
          a_n  = a_q << CHUNK;
          b_n  = b_q << CHUNK;
          if (fin) begin
            tk_n    = res;
            mp_n    = res ^ pred_q;
            state_n = DONE;
          end else begin
            idx_n = idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      idx    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= EQ;
      pred_q <= 1'b0;
      lt_q   <= 1'b0;
      ne_q   <= 1'b0;
      tk_q   <= 1'b0;
      mp_q   <= 1'b0;
    end else begin
      state  <= state_n;
      idx    <= idx_n;
      a_q    <= a_n;
      b_q    <= b_n;
      op_q   <= op_n;
      pred_q <= pred_n;
      lt_q   <= lt_n;
      ne_q   <= ne_n;
      tk_q   <= tk_n;
      mp_q   <= mp_n;
    end
  end

  assign in_ready   = (state == IDLE);
  assign out_valid  = (state == DONE);
  assign taken      = tk_q;
  assign mispredict = mp_q;

endmodule

// File: tb/tb_branch_comp_iter.sv
// Bench for branch_comp_iter: early-exit and fixed-latency instances
// checked every cycle against a transaction-level model.
module tb_branch_comp_iter;
  import br_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid   [2];
  logic        in_ready   [2];
  logic [31:0] a          [2];
  logic [31:0] b          [2];
  br_op_t      br_op      [2];
  logic        pred_taken [2];
  logic        flush      [2];
  logic        out_valid  [2];
  logic        out_ready  [2];
  logic        taken      [2];
  logic        mispredict [2];

  branch_comp_iter #(
    .XLEN(32), .CHUNK(8), .EARLY_EXIT(1)
  ) dut_ee (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a(a[0]), .b(b[0]), .br_op(br_op[0]),
    .pred_taken(pred_taken[0]), .flush(flush[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .taken(taken[0]), .mispredict(mispredict[0])
  );

  branch_comp_iter #(
    .XLEN(32), .CHUNK(8), .EARLY_EXIT(0)
  ) dut_fx (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a(a[1]), .b(b[1]), .br_op(br_op[1]),
    .pred_taken(pred_taken[1]), .flush(flush[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .taken(taken[1]), .mispredict(mispredict[1])
  );

  int errors = 0;
  int checks = 0;
  bit live   = 1'b0;
  bit m_pend [2];
  int m_wait [2];
  bit m_tk   [2];
  bit m_mp   [2];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit mt(br_op_t op, logic [31:0] x, logic [31:0] y);
    case (op)
      EQ:      return x == y;
      NE:      return x != y;
      LT:      return $signed(x) < $signed(y);
      GE:      return $signed(x) >= $signed(y);
      LTU:     return x < y;
      GEU:     return x >= y;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int mk(logic [31:0] x, logic [31:0] y, bit ee);
    if (!ee) return 3;
    for (int i = 0; i < 4; i++)
      if (x[31-8*i -: 8] != y[31-8*i -: 8]) return i;
    return 3;
  endfunction

  always @(negedge clk) begin
    if (live) begin
      for (int d = 0; d < 2; d++) begin
        bit ev;
        ev = m_pend[d] && (m_wait[d] == 0);
        chk($sformatf("in_ready%0d", d), 32'(in_ready[d]), 32'(!m_pend[d]));
        chk($sformatf("out_valid%0d", d), 32'(out_valid[d]), 32'(ev));
        if (ev) begin
          chk($sformatf("taken%0d", d), 32'(taken[d]), 32'(m_tk[d]));
          chk($sformatf("mispredict%0d", d), 32'(mispredict[d]), 32'(m_mp[d]));
        end
        if (m_pend[d] && m_wait[d] > 0) m_wait[d]--;
      end
    end
  end

  task automatic start(int d, logic [31:0] x, logic [31:0] y,
                       br_op_t op, bit pred, int k, bit tk);
    @(negedge clk);
    a[d] = x; b[d] = y; br_op[d] = op;
    pred_taken[d] = pred; in_valid[d] = 1'b1;
    @(posedge clk);
    #1;
    in_valid[d] = 1'b0;
    m_tk[d] = tk; m_mp[d] = tk ^ pred;
    m_wait[d] = k + 1; m_pend[d] = 1'b1;
  endtask

  task automatic run(int d, logic [31:0] x, logic [31:0] y, br_op_t op,
                     bit pred, int k, bit tk, int hold, bit vhold);
    start(d, x, y, op, pred, k, tk);
    repeat (k + 1) @(posedge clk);
    repeat (hold) @(posedge clk);
    @(negedge clk);
    out_ready[d] = 1'b1;
    in_valid[d] = vhold;
    @(posedge clk);
    #1;
    out_ready[d] = 1'b0;
    in_valid[d] = 1'b0;
    m_pend[d] = 1'b0;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = 0; a[d] = 0; b[d] = 0; br_op[d] = EQ;
      pred_taken[d] = 0; flush[d] = 0; out_ready[d] = 0;
      m_pend[d] = 0; m_wait[d] = 0; m_tk[d] = 0; m_mp[d] = 0;
    end
    rst_n = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready[0]), 1);
    chk("rst_out_valid", 32'(out_valid[0]), 0);
    chk("rst_taken", 32'(taken[0]), 0);
    chk("rst_mispredict", 32'(mispredict[0]), 0);
    #20;
    @(negedge clk);
    #1 rst_n = 1'b1;
    live = 1'b1;

    chk("model_eq", 32'(mt(EQ, 32'h12345678, 32'h12345678)), 1);
    chk("model_lt", 32'(mt(LT, 32'hFFFFFFFF, 32'h1)), 1);
    chk("model_ltu", 32'(mt(LTU, 32'hFFFFFFFF, 32'h1)), 0);
    chk("model_geu_k", mk(32'h100, 32'hFF, 1), 2);

    run(0, 32'h12345678, 32'h12345678, EQ, 0, 3, 1, 0, 0);
    run(0, 32'hFFFFFFFF, 32'h00000001, LT, 0, 0, 1, 1, 0);
    run(0, 32'hFFFFFFFF, 32'h00000001, LTU, 1, 0, 0, 0, 0);
    run(0, 32'h00000100, 32'h000000FF, GEU, 1, 2, 1, 2, 0);
    run(1, 32'h80000000, 32'h00000000, NE, 1, 3, 1, 0, 0);
    run(0, 32'h00000005, 32'h00000005, br_op_t'(3'd2), 1, 3, 0, 0, 0);
    run(0, 32'h80000000, 32'h00000001, GE, 1, 0, 0, 5, 1);

    // flush in the second busy cycle: no result may appear
    start(0, 32'hA5A5A5A5, 32'hA5A5A5A5, EQ, 0, 3, 1);
    @(posedge clk);
    @(negedge clk);
    flush[0] = 1'b1;
    @(posedge clk);
    #1;
    flush[0] = 1'b0;
    m_pend[0] = 1'b0;
    repeat (6) @(negedge clk);

    // flush beats a same-cycle request in idle
    @(negedge clk);
    a[0] = 0; b[0] = 0; in_valid[0] = 1'b1; flush[0] = 1'b1;
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0; flush[0] = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 60; i++) begin
      int d;
      logic [31:0] x, y;
      br_op_t op;
      bit pred;
      d = $urandom_range(0, 1);
      x = $urandom;
      y = x;
      for (int c = 0; c < 4; c++)
        if ($urandom_range(0, 3) == 0) y[8*c +: 8] = 8'($urandom);
      if ($urandom_range(0, 4) == 0) y = $urandom;
      op = br_op_t'(3'($urandom_range(0, 7)));
      pred = 1'($urandom);
      run(d, x, y, op, pred, mk(x, y, d == 0), mt(op, x, y),
          $urandom_range(0, 3), 1'($urandom));
    end

    // reset mid-busy after a taken, mispredicted result
    run(0, 32'h1, 32'h1, EQ, 0, 3, 1, 0, 0);
    start(0, 32'h0, 32'h0, EQ, 0, 3, 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    m_pend[0] = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid[0]), 0);
    chk("mid_rst_in_ready", 32'(in_ready[0]), 1);
    chk("mid_rst_taken", 32'(taken[0]), 0);
    chk("mid_rst_mispredict", 32'(mispredict[0]), 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    run(0, 32'h7F000000, 32'h80000000, LT, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);

    live = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
